// File: rtl/serial_subtractor_4bit_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_4bit_pkg
//   Shared definitions for the bit-serial subtractor:
//   - default operand width and bit-counter width
//   - FSM state encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   - fs_bit(): 1-bit full-subtractor equation, returned as {borrow, diff}
// -----------------------------------------------------------------------------
package serial_subtractor_4bit_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One bit of a - b - bi. Borrow is raised when the minuend bit is smaller
  // than the subtrahend bit, or when the two are equal and a borrow arrives.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bi);
    logic diff_s;
    logic borrow_s;
    diff_s   = a ^ b ^ bi;
    borrow_s = (~a & b) | (~(a ^ b) & bi);
    return {borrow_s, diff_s};
  endfunction

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor_1bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_1bit
//   Purely combinational single-bit subtractor: d = a - b - bi (mod 2), with
//   bo the borrow out to the next more significant bit.
// Ports:
//   a   in  1  minuend bit
//   b   in  1  subtrahend bit
//   bi  in  1  borrow in
//   d   out 1  difference bit
//   bo  out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor_1bit
  import serial_subtractor_4bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic [1:0] res_s;

  // Single evaluation of the shared subtractor equation.
  always_comb begin
    res_s = fs_bit(a, b, bi);
  end

  assign d  = res_s[0];
  assign bo = res_s[1];

endmodule

// File: rtl/serial_subtractor_4bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_4bit
//   Bit-serial subtractor computing {Bo, D} = A - B - Bi over WIDTH clocks,
//   LSB first, with a single full_subtractor_1bit and a registered borrow.
//   A start/done handshake fronts the datapath; D/Bo are held until the next
//   completion. All outputs are registered.
// Ports:
//   sys_clk    in   1      rising-edge clock
//   sys_rst_n  in   1      synchronous active-low reset (aborts any operation)
//   start      in   1      request, sampled only while idle
//   A          in   WIDTH  minuend, captured on accepted start
//   B          in   WIDTH  subtrahend, captured on accepted start
//   Bi         in   1      borrow in, captured on accepted start
//   busy       out  1      high in SHIFT and DONE
//   done       out  1      one-cycle completion pulse
//   D          out  WIDTH  difference
//   Bo         out  1      borrow out
// -----------------------------------------------------------------------------
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_sr_q,  a_sr_d;
  logic [WIDTH-1:0] b_sr_q,  b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             br_q,    br_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic             bo_q,    bo_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;

  logic             fs_d_s;
  logic             fs_bo_s;

  // The one and only bit-slice: LSBs of the operand shift registers plus the
  // running borrow.
  full_subtractor_1bit u_fs (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .bi (br_q),
    .d  (fs_d_s),
    .bo (fs_bo_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    d_d      = d_q;
    bo_d     = bo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d   = A;
          b_sr_d   = B;
          br_d     = Bi;
          cnt_d    = {CNT_W{1'b0}};
          res_sr_d = {WIDTH{1'b0}};
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // Difference bits enter at the MSB so that after WIDTH shifts the
        // LSB-first stream sits in natural bit order.
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = {fs_d_s, res_sr_q[WIDTH-1:1]};
        br_d     = fs_bo_s;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          d_d     = {fs_d_s, res_sr_q[WIDTH-1:1]};
          bo_d    = fs_bo_s;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy follows the state being entered so it is aligned with it.
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_sr_q <= {WIDTH{1'b0}};
      br_q     <= 1'b0;
      d_q      <= {WIDTH{1'b0}};
      bo_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_4bit
//   Self-checking bench for serial_subtractor_4bit. Expected results come from
//   plain integer arithmetic (A - B - Bi) and the handshake timing rules.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bi;
  logic       busy;
  logic       done;
  logic [3:0] D;
  logic       Bo;

  int checks   = 0;
  int failures = 0;

  serial_subtractor_4bit dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .Bi        (Bi),
    .busy      (busy),
    .done      (done),
    .D         (D),
    .Bo        (Bo)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One operation: start at a negedge, follow it to the done pulse, check
  // latency, busy width, result, and the cycle after done. poke_at > 0
  // raises a second start (with different operands) after that many edges.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input int poke_at, input string tag);
    int         diff;
    int         edges;
    int         busy_cnt;
    logic [3:0] exp_d;
    logic       exp_bo;

    diff   = int'(a) - int'(b) - int'(bi);
    exp_bo = (diff < 0);
    exp_d  = 4'((diff + 32) % 16);

    @(negedge sys_clk);
    A = a; B = b; Bi = bi; start = 1'b1;
    @(negedge sys_clk);
    start    = 1'b0;
    // Operands are no longer relevant once captured.
    A = 4'($urandom); B = 4'($urandom); Bi = 1'($urandom);
    edges    = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (edges == poke_at) begin
        start = 1'b1; A = ~a; B = ~b; Bi = ~bi;
      end else begin
        start = 1'b0;
      end
      @(negedge sys_clk);
      edges++;
    end
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    chk({tag, " latency"}, edges, 5);
    chk({tag, " busy_cycles"}, busy_cnt, 5);
    chk({tag, " D"}, D, exp_d);
    chk({tag, " Bo"}, Bo, exp_bo);
    @(negedge sys_clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " idle_busy"}, busy, 1'b0);
    chk({tag, " D_held"}, D, exp_d);
  endtask

  initial begin
    int dones;

    sys_rst_n = 1'b0;
    start     = 1'b0;
    A = 4'd0; B = 4'd0; Bi = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst D",    D,    4'd0);
    chk("rst Bo",   Bo,   1'b0);
    sys_rst_n = 1'b1;

    // Idle with start low holds everything.
    repeat (3) @(negedge sys_clk);
    chk("idle busy", busy, 1'b0);
    chk("idle done", done, 1'b0);

    // Directed cases.
    run_op(4'b0000, 4'b0000, 1'b0, 0, "zero");
    run_op(4'b0000, 4'b0000, 1'b1, 0, "wrap");
    run_op(4'b1111, 4'b1111, 1'b0, 0, "ff_b0");
    run_op(4'b1111, 4'b1111, 1'b1, 0, "ff_b1");
    run_op(4'b0101, 4'b1010, 1'b0, 0, "5m10");
    run_op(4'b1010, 4'b0101, 1'b0, 0, "10m5");

    // Start while busy is ignored: one result, one done pulse.
    run_op(4'b1001, 4'b0011, 1'b1, 2, "ignored_start");
    dones = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (done === 1'b1) dones++;
    end
    chk("ignored_start extra_done", dones, 0);
    chk("ignored_start D_kept", D, 4'b0101);

    // Reset during SHIFT aborts with no done and clears outputs.
    run_op(4'b0101, 4'b1010, 1'b0, 0, "pre_reset");
    @(negedge sys_clk);
    A = 4'd3; B = 4'd1; Bi = 1'b0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst D",    D,    4'd0);
    chk("midrst Bo",   Bo,   1'b0);
    sys_rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (done === 1'b1) dones++;
    end
    chk("midrst no_done", dones, 0);
    chk("midrst busy_after", busy, 1'b0);

    // Exhaustive sweep of all A/B/Bi combinations.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run_op(v[3:0], v[7:4], v[8], 0, "exh");
    end

    // Randomized operations with random mid-operation start pokes and gaps.
    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 4)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
